// File: rtl/spi_slave_if.sv
// Bus bundle between the SPI responder and its surroundings: the serial pins plus
// the parallel reply/receive side.
`timescale 1ns/1ps
interface spi_slave_if #(
   parameter int DATA_BIT_WIDTH = 16
);
   logic                      SCK;
   logic                      SEL;
   logic                      MOSI;
   logic                      MISO;
   logic                      MISO_OE;
   logic [DATA_BIT_WIDTH-1:0] TX_DATA;
   logic                      TX_LOAD;
   logic                      TX_READY;
   logic [DATA_BIT_WIDTH-1:0] RX_DATA;
   logic                      RX_VALID;
   logic                      FRAME_ERR;
   logic                      BUSY;

   modport master (
      output SCK, SEL, MOSI, TX_DATA, TX_LOAD,
      input  MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, FRAME_ERR, BUSY
   );

   modport slave (
      input  SCK, SEL, MOSI, TX_DATA, TX_LOAD,
      output MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, FRAME_ERR, BUSY
   );
endinterface

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCK/SEL/MOSI in the clk domain, receives one LSB-first
// word per SEL assertion and shifts a preloaded reply word out MSB-first.
`timescale 1ns/1ps
module spi_slave #(
   parameter int DATA_BIT_WIDTH = 16,
   parameter int SYNC_STAGES    = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   spi_slave_if.slave bus
);
   localparam int W  = DATA_BIT_WIDTH;
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] FULL = CW'(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   logic [SYNC_STAGES-1:0] sck_sync, sel_sync, mosi_sync;
   logic                   sck_d, sel_d;
   logic                   sck_s, sel_s, mosi_s;
   logic                   sck_rise, sck_fall, sel_rise, sel_fall;

   state_t          state_q, state_d;
   logic [W-1:0]    tx_shift_q, tx_shift_d;
   logic [W-1:0]    rx_shift_q, rx_shift_d;
   logic [CW-1:0]   bitcnt_q, bitcnt_d;
   logic            ovf_q, ovf_d;
   logic [W-1:0]    hold_q, hold_d;
   logic            tx_ready_q, tx_ready_d;
   logic [W-1:0]    rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            busy_q, busy_d;
   logic            miso_q, miso_d;
   logic            miso_oe_q, miso_oe_d;

   // Synchronizer chains plus one extra flop on SCK/SEL for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync  <= '0;
         sel_sync  <= '0;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
         sel_d     <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.SCK};
         sel_sync  <= {sel_sync[SYNC_STAGES-2:0], bus.SEL};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
         sck_d     <= sck_s;
         sel_d     <= sel_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign sel_s    = sel_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign sel_rise = sel_s & ~sel_d;
   assign sel_fall = ~sel_s & sel_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         bitcnt_q    <= '0;
         ovf_q       <= 1'b0;
         hold_q      <= '0;
         tx_ready_q  <= 1'b1;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         bitcnt_q    <= bitcnt_d;
         ovf_q       <= ovf_d;
         hold_q      <= hold_d;
         tx_ready_q  <= tx_ready_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      bitcnt_d    = bitcnt_q;
      ovf_d       = ovf_q;
      hold_d      = hold_q;
      tx_ready_d  = tx_ready_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      busy_d      = busy_q;
      miso_d      = miso_q;
      miso_oe_d   = miso_oe_q;

      unique case (state_q)
         IDLE: begin
            if (sel_rise) begin
               state_d    = SHIFT;
               tx_shift_d = hold_q;
               bitcnt_d   = '0;
               rx_shift_d = '0;
               ovf_d      = 1'b0;
               busy_d     = 1'b1;
               miso_oe_d  = 1'b1;
               miso_d     = hold_q[W-1];
               tx_ready_d = 1'b1;
            end
         end
         SHIFT: begin
            // A rise coinciding with SEL falling still captures its bit
            if (sck_rise) begin
               if (bitcnt_q < FULL) begin
                  rx_shift_d = {mosi_s, rx_shift_q[W-1:1]};
                  bitcnt_d   = bitcnt_q + CW'(1);
                  if (bitcnt_q == LAST) begin
                     rx_data_d  = {mosi_s, rx_shift_q[W-1:1]};
                     rx_valid_d = 1'b1;
                  end
               end else begin
                  ovf_d = 1'b1;
               end
            end
            if (sck_fall) begin
               if (bitcnt_q < FULL) begin
                  tx_shift_d = tx_shift_q << 1;
                  miso_d     = tx_shift_q[W-2];
               end else begin
                  miso_d = 1'b0;
               end
            end
            if (sel_fall) state_d = DONE;
         end
         DONE: begin
            frame_err_d = (bitcnt_q < FULL) || ovf_q;
            busy_d      = 1'b0;
            miso_oe_d   = 1'b0;
            miso_d      = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A load on the frame-start cycle wins over the ready flag set above
      if (bus.TX_LOAD) begin
         hold_d     = bus.TX_DATA;
         tx_ready_d = 1'b0;
      end
   end

   assign bus.MISO      = miso_q;
   assign bus.MISO_OE   = miso_oe_q;
   assign bus.TX_READY  = tx_ready_q;
   assign bus.RX_DATA   = rx_data_q;
   assign bus.RX_VALID  = rx_valid_q;
   assign bus.FRAME_ERR = frame_err_q;
   assign bus.BUSY      = busy_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged SPI master drives frames while a transaction-level
// model predicts the reply word, received word, strobe counts and status flags.
`timescale 1ns/1ps
module tb_spi_slave;
   localparam int W    = 16;
   localparam int SYNC = 2;

   logic clk;
   logic rst_n;

   spi_slave_if #(.DATA_BIT_WIDTH(W)) bus ();

   spi_slave #(.DATA_BIT_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Transaction-level model state
   logic [W-1:0] m_hold;
   logic         m_ready;
   logic [W-1:0] m_rx;
   logic [W-1:0] exp_prev;
   logic [W-1:0] exp_word;
   int           frame_id = 0;
   bit           in_frame = 1'b0;

   // Owned by the monitor
   int seen_id = -1;
   int rx_cnt  = 0;
   int err_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Per-cycle monitor: strobe counting plus cycle-level invariants
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.RX_VALID) begin
            rx_cnt++;
            seen_id = frame_id;
         end
         if (bus.FRAME_ERR) err_cnt++;
         check("rx_data_cycle", 32'(bus.RX_DATA), 32'((seen_id == frame_id) ? exp_word : exp_prev));
         check("miso_idle_low", 32'(bus.MISO & ~bus.MISO_OE), 32'(0));
         if (in_frame) begin
            check("busy_in_frame", 32'(bus.BUSY), 32'(1));
            check("oe_in_frame", 32'(bus.MISO_OE), 32'(1));
         end
      end
   end

   task automatic load_word(input logic [W-1:0] v);
      @(posedge clk); #1;
      bus.TX_DATA = v;
      bus.TX_LOAD = 1'b1;
      @(posedge clk); #1;
      bus.TX_LOAD = 1'b0;
      m_hold  = v;
      m_ready = 1'b0;
      check("tx_ready_after_load", 32'(bus.TX_READY), 32'(0));
   endtask

   task automatic run_frame(input logic [W-1:0] mosi_w, input int nrise, input bit load_start,
                            input logic [W-1:0] load_val, input bit abort, output logic [W-1:0] got);
      logic [W-1:0] sent;
      logic [W-1:0] mask;
      int           rx0, err0, nbits;
      logic         b;
      sent     = m_hold;
      got      = '0;
      exp_prev = m_rx;
      exp_word = mosi_w;
      frame_id++;
      rx0  = rx_cnt;
      err0 = err_cnt;
      @(posedge clk); #1;
      bus.SEL = 1'b1;
      repeat (SYNC) @(posedge clk);
      #1;
      if (load_start) begin
         bus.TX_DATA = load_val;
         bus.TX_LOAD = 1'b1;
      end
      @(posedge clk); #1;
      bus.TX_LOAD = 1'b0;
      if (load_start) begin
         m_hold  = load_val;
         m_ready = 1'b0;
      end else begin
         m_ready = 1'b1;
      end
      repeat (6) @(posedge clk);
      #1;
      in_frame = 1'b1;
      check("tx_ready_frame_start", 32'(bus.TX_READY), 32'(m_ready));
      for (int i = 0; i < nrise; i++) begin
         bus.MOSI = (i < W) ? mosi_w[i] : 1'($urandom);
         repeat (5) @(posedge clk);
         @(negedge clk);
         b = bus.MISO;
         if (i < W) got[W-1-i] = b;
         else check("miso_after_last_bit", 32'(b), 32'(0));
         @(posedge clk); #1;
         bus.SCK = 1'b1;
         repeat (7) @(posedge clk);
         #1;
         bus.SCK = 1'b0;
      end
      if (abort) begin
         in_frame = 1'b0;
         rst_n    = 1'b0;
         #1;
         check("rst_busy", 32'(bus.BUSY), 32'(0));
         check("rst_miso_oe", 32'(bus.MISO_OE), 32'(0));
         check("rst_miso", 32'(bus.MISO), 32'(0));
         check("rst_rx_data", 32'(bus.RX_DATA), 32'(0));
         check("rst_tx_ready", 32'(bus.TX_READY), 32'(1));
         check("rst_rx_valid", 32'(bus.RX_VALID), 32'(0));
         check("rst_frame_err", 32'(bus.FRAME_ERR), 32'(0));
         bus.SEL  = 1'b0;
         bus.MOSI = 1'b0;
         m_hold   = '0;
         m_ready  = 1'b1;
         m_rx     = '0;
         exp_prev = '0;
         frame_id++;
         repeat (3) @(posedge clk);
         #1;
         rst_n = 1'b1;
         return;
      end
      repeat (6) @(posedge clk);
      #1;
      in_frame = 1'b0;
      bus.SEL  = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      nbits = (nrise < W) ? nrise : W;
      mask  = W'(32'hFFFF << (W - nbits));
      check("miso_word", 32'(got & mask), 32'(sent & mask));
      if (nrise >= W) m_rx = mosi_w;
      check("rx_valid_count", 32'(rx_cnt - rx0), 32'(nrise >= W));
      check("frame_err_count", 32'(err_cnt - err0), 32'(nrise != W));
      check("rx_data_end", 32'(bus.RX_DATA), 32'(m_rx));
      check("busy_end", 32'(bus.BUSY), 32'(0));
      check("miso_oe_end", 32'(bus.MISO_OE), 32'(0));
      check("miso_end", 32'(bus.MISO), 32'(0));
      check("tx_ready_end", 32'(bus.TX_READY), 32'(m_ready));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] got;
      logic [W-1:0] w;
      int           r, n;
      rst_n       = 1'b0;
      bus.SCK     = 1'b0;
      bus.SEL     = 1'b0;
      bus.MOSI    = 1'b0;
      bus.TX_DATA = '0;
      bus.TX_LOAD = 1'b0;
      m_hold      = '0;
      m_ready     = 1'b1;
      m_rx        = '0;
      exp_prev    = '0;
      exp_word    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_miso", 32'(bus.MISO), 32'(0));
      check("reset_miso_oe", 32'(bus.MISO_OE), 32'(0));
      check("reset_rx_valid", 32'(bus.RX_VALID), 32'(0));
      check("reset_frame_err", 32'(bus.FRAME_ERR), 32'(0));
      check("reset_busy", 32'(bus.BUSY), 32'(0));
      check("reset_rx_data", 32'(bus.RX_DATA), 32'(0));
      check("reset_tx_ready", 32'(bus.TX_READY), 32'(1));
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      // Basic exchange with literal expectations
      load_word(16'hA5C3);
      run_frame(16'h1234, 16, 1'b0, '0, 1'b0, got);
      check("lit_miso_a5c3", 32'(got), 32'h0000A5C3);
      check("lit_rx_1234", 32'(bus.RX_DATA), 32'h00001234);

      // Loopback-style exchange
      load_word(16'h0F0F);
      run_frame(16'hBEEF, 16, 1'b0, '0, 1'b0, got);
      check("lit_miso_0f0f", 32'(got), 32'h00000F0F);
      check("lit_rx_beef", 32'(bus.RX_DATA), 32'h0000BEEF);

      // Short frame: 9 rises
      run_frame(16'h5A5A, 9, 1'b0, '0, 1'b0, got);
      check("lit_rx_kept_beef", 32'(bus.RX_DATA), 32'h0000BEEF);

      // Overflowed frame: 17 rises
      load_word(16'h8001);
      run_frame(16'hC0DE, 17, 1'b0, '0, 1'b0, got);
      check("lit_rx_c0de", 32'(bus.RX_DATA), 32'h0000C0DE);

      // Load coincident with frame start
      load_word(16'hFFFF);
      run_frame(16'h1111, 16, 1'b1, 16'h0001, 1'b0, got);
      check("lit_miso_ffff", 32'(got), 32'h0000FFFF);
      check("lit_tx_ready_held", 32'(bus.TX_READY), 32'(0));
      run_frame(16'h2222, 16, 1'b0, '0, 1'b0, got);
      check("lit_miso_0001", 32'(got), 32'h00000001);

      // Reset mid-frame after 7 bits, then a clean frame
      load_word(16'h1357);
      run_frame(16'h9999, 7, 1'b0, '0, 1'b1, got);
      repeat (4) @(posedge clk);
      run_frame(16'h00FF, 16, 1'b0, '0, 1'b0, got);
      check("lit_rx_00ff", 32'(bus.RX_DATA), 32'h000000FF);
      check("lit_miso_after_rst", 32'(got), 32'h00000000);

      // Randomized frames
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(0, 1) == 1) load_word(W'($urandom));
         r = $urandom_range(0, 5);
         n = (r == 0) ? $urandom_range(1, W - 1) : (r == 1) ? W + 1 : W;
         w = W'($urandom);
         run_frame(w, n, ($urandom_range(0, 3) == 0), W'($urandom), 1'b0, got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (slave) for the FPGA's SPI master links. Pairs with our SPI_Master framing: SEL active-high, SCK idle-low, MOSI LSB-first, MISO MSB-first, one DATA_BIT_WIDTH word per SEL assertion.
- Oversamples SCK, SEL and MOSI in the system clock domain and shifts a preloaded reply word out on MISO.
- Presents each received word with a one-cycle valid strobe.
- Used for FPGA-to-FPGA links and for loopback verification of SPI_Master.

Parameters:
- DATA_BIT_WIDTH, 16: bits per frame; must be at least 2.
- SYNC_STAGES, 2: synchronizer flops on SCK, SEL and MOSI before edge detection; must be at least 2.

Ports:
- clk  in  1  system clock; must be at least 8x the SCK frequency.
- rst_n  in  1  asynchronous active-low reset.
- SCK  in  1  SPI clock from the master; idle low.
- SEL  in  1  frame select; active high.
- MOSI  in  1  serial data from the master, LSB first.
- MISO  out  1  serial data to the master, MSB first.
- MISO_OE  out  1  MISO drive enable; high while the synced SEL is high.
- TX_DATA  in  DATA_BIT_WIDTH  reply word.
- TX_LOAD  in  1  single-cycle strobe; writes TX_DATA into the holding register.
- TX_READY  out  1  holding register is empty.
- RX_DATA  out  DATA_BIT_WIDTH  last good received word.
- RX_VALID  out  1  one-cycle pulse when RX_DATA updates.
- FRAME_ERR  out  1  one-cycle pulse when a frame is malformed.
- BUSY  out  1  a frame is in progress.

Behaviour:
- Reset (async assert, sync deassert):
  - state IDLE; MISO, MISO_OE, RX_VALID, FRAME_ERR, BUSY all 0.
  - RX_DATA 0; TX_READY 1; hold register 0; all synchronizer flops 0.
- Sync and edge detect:
  - Each input passes through SYNC_STAGES flops, then one extra flop for edge detection.
  - sck_rise, sck_fall, sel_rise and sel_fall are one-cycle pulses.
  - Input-to-detect latency is SYNC_STAGES+1 clk.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On sel_rise, go to SHIFT. The same cycle:
    - copy the hold register to tx_shift; bitcnt=0; rx_shift=0; ovf=0.
    - BUSY=1, MISO_OE=1, and MISO = bit DATA_BIT_WIDTH-1 of the copied word.
  - If a word was loaded, TX_READY goes to 1 the same cycle.
  - If no word was loaded, the stale hold value is sent. After reset the hold value is 0.
- SHIFT:
  - sck_rise with bitcnt<DATA_BIT_WIDTH:
    - rx_shift <= {synced MOSI, rx_shift[W-1:1]}; bitcnt++.
    - If bitcnt reaches DATA_BIT_WIDTH, RX_DATA <= the completed word and RX_VALID pulses the next cycle.
  - sck_rise with bitcnt==DATA_BIT_WIDTH: ovf=1; data is ignored.
  - sck_fall with bitcnt<DATA_BIT_WIDTH: tx_shift <= tx_shift<<1; MISO follows the new MSB.
  - sck_fall with bitcnt==DATA_BIT_WIDTH: MISO held at 0.
  - sel_fall: go to DONE.
- DONE (one cycle):
  - If bitcnt<DATA_BIT_WIDTH or ovf=1, pulse FRAME_ERR. An overflowed frame's word has already been delivered.
  - Clear BUSY and MISO_OE; force MISO to 0; go to IDLE.
- Short frames: RX_DATA is not updated and RX_VALID does not pulse.
- TX_LOAD:
  - Accepted in any state; hold <= TX_DATA; TX_READY=0 the next cycle.
  - Writing while TX_READY=0 overwrites the hold register; no error is raised.
  - Loads during SHIFT never affect the word being shifted.
  - If TX_LOAD coincides with sel_rise, the old hold value is shifted and the new value is retained; TX_READY stays 0.
- Coincident events:
  - sck_rise and sel_fall in the same cycle: the bit is captured, then DONE.
  - sel_rise while in DONE: ignored. SEL must be low for at least SYNC_STAGES+2 clk between frames.
- rst_n asserted mid-frame: everything returns to reset values immediately; the partial word is discarded.
- SCK edges while SEL is low: ignored.

Test Plan:
- Reset, load TX_DATA=16'hA5C3, master sends 16'h1234 LSB-first at clk/16: MISO sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. RX_DATA=16'h1234 with a single RX_VALID pulse; FRAME_ERR stays 0; TX_READY returns to 1 at frame start.
- Loopback with SPI_Master, DATA_IN=16'hBEEF: slave RX_DATA=16'hBEEF. Master DATA_OUT equals the slave's preloaded 16'h0F0F.
- Short frame, SEL dropped after 9 SCK rises: FRAME_ERR pulses once; RX_VALID never pulses; RX_DATA keeps its prior value; BUSY falls.
- 17 SCK rises in one frame: RX_VALID pulses after rise 16 with the correct word. FRAME_ERR pulses at SEL fall. MISO is 0 after bit 16.
- TX_LOAD 16'h0001 on the sel_rise cycle, with 16'hFFFF previously held: frame shifts 16'hFFFF out. The next frame shifts 16'h0001 out.
- rst_n pulsed low after bit 7: all outputs reset within 1 clk. The next full frame of 16'h00FF is received correctly.
